// File: rtl/tag_fifo_pkg.sv
// Rename-tag constants and types shared by the tag free-list, the register
// status table and dispatch.
package tag_fifo_pkg;

    localparam int unsigned W_TAG = 6;
    localparam int unsigned N_TAG = 2 ** W_TAG;

    typedef logic [W_TAG-1:0] tag_t;
    typedef logic [W_TAG:0]   cnt_t;

endpackage

// File: rtl/tag_fifo_if.sv
// Dispatch/commit-side handshake of the rename-tag free-list.
interface tag_fifo_if;
    import tag_fifo_pkg::*;

    logic flush;
    logic alloc_req;
    logic alloc_valid;
    tag_t alloc_tag;
    logic free_wen;
    tag_t free_tag;
    cnt_t free_count;
    logic full;
    logic overflow_err;

    modport master (
        output flush, alloc_req, free_wen, free_tag,
        input  alloc_valid, alloc_tag, free_count, full, overflow_err
    );

    modport slave (
        input  flush, alloc_req, free_wen, free_tag,
        output alloc_valid, alloc_tag, free_count, full, overflow_err
    );

endinterface

// File: rtl/tag_fifo.sv
// First-word-fall-through free-list of rename tags, initialised full with the
// identity order on reset and flush.
module tag_fifo
    import tag_fifo_pkg::*;
(
    input logic       clk,
    input logic       reset,
    tag_fifo_if.slave bus
);

    tag_t mem_q [N_TAG];
    tag_t mem_d [N_TAG];
    tag_t rd_ptr_q, rd_ptr_d;
    tag_t wr_ptr_q, wr_ptr_d;
    cnt_t cnt_q, cnt_d;
    logic ovf_q, ovf_d;

    logic empty;
    logic is_full;
    logic alloc_fire;
    logic free_fire;

    // Occupancy comes only from the count; pointers are equal both when empty and full.
    assign empty      = (cnt_q == '0);
    assign is_full    = (cnt_q == cnt_t'(N_TAG));
    assign alloc_fire = bus.alloc_req & ~empty;
    assign free_fire  = bus.free_wen & ~is_full;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (bus.flush) begin
            for (int unsigned i = 0; i < N_TAG; i++) begin
                mem_d[i] = tag_t'(i);
            end
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = cnt_t'(N_TAG);
        end else begin
            if (bus.free_wen && is_full) begin
                ovf_d = 1'b1;
            end
            if (alloc_fire) begin
                rd_ptr_d = rd_ptr_q + tag_t'(1);
            end
            if (free_fire) begin
                mem_d[wr_ptr_q] = bus.free_tag;
                wr_ptr_d        = wr_ptr_q + tag_t'(1);
            end
            if (alloc_fire && !free_fire) begin
                cnt_d = cnt_q - cnt_t'(1);
            end else if (free_fire && !alloc_fire) begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_TAG; i++) begin
                mem_q[i] <= tag_t'(i);
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= cnt_t'(N_TAG);
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.alloc_valid  = ~empty;
    assign bus.alloc_tag    = mem_q[rd_ptr_q];
    assign bus.free_count   = cnt_q;
    assign bus.full         = is_full;
    assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_tag_fifo.sv
// Directed scenarios plus random alloc/free/flush traffic checked against a
// queue model of the free-list and an outstanding-tag set.
module tb_tag_fifo;
    import tag_fifo_pkg::*;

    logic clk = 1'b0;
    logic reset;

    tag_fifo_if bus ();

    tag_fifo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int free_q[$];
    int out_q[$];
    bit in_use[N_TAG];
    bit ovf;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_init();
        free_q.delete();
        out_q.delete();
        for (int i = 0; i < int'(N_TAG); i++) begin
            free_q.push_back(i);
            in_use[i] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("alloc_valid", 32'(bus.alloc_valid), 32'(free_q.size() != 0));
        if (free_q.size() != 0) begin
            check("alloc_tag", 32'(bus.alloc_tag), 32'(free_q[0]));
            check("dup_tag", 32'(in_use[bus.alloc_tag]), 32'd0);
        end
        check("free_count", 32'(bus.free_count), 32'(free_q.size()));
        check("full", 32'(bus.full), 32'(free_q.size() == int'(N_TAG)));
        check("overflow_err", 32'(bus.overflow_err), 32'(ovf));
    endtask

    task automatic drive(input bit a, input bit f, input int ft, input bit fl);
        bus.alloc_req = a;
        bus.free_wen  = f;
        bus.free_tag  = tag_t'(ft);
        bus.flush     = fl;
    endtask

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic step();
        bit a_fire, f_fire;
        int t;
        @(posedge clk);
        if (bus.flush) begin
            model_init();
        end else begin
            a_fire = bus.alloc_req && (free_q.size() != 0);
            f_fire = bus.free_wen && (free_q.size() != int'(N_TAG));
            if (bus.free_wen && !f_fire) ovf = 1'b1;
            if (a_fire) begin
                t = free_q.pop_front();
                in_use[t] = 1'b1;
                out_q.push_back(t);
            end
            if (f_fire) begin
                t = int'(bus.free_tag);
                free_q.push_back(t);
                in_use[t] = 1'b0;
                for (int i = 0; i < out_q.size(); i++) begin
                    if (out_q[i] == t) begin
                        out_q.delete(i);
                        break;
                    end
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic async_reset_pulse();
        drive(0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        model_init();
        ovf = 1'b0;
        check_outputs();
        #1 reset = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        reset = 1'b0;
        ovf   = 1'b0;
        model_init();
        #12;
        check_outputs();
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;

        // Drain all tags in order.
        drive(1, 0, 0, 0);
        repeat (64) step();

        // Empty: simultaneous free and alloc, no bypass.
        drive(1, 1, 'h2A, 0);
        step();
        check("bypass_tag", 32'(bus.alloc_tag), 32'h2A);

        // Steady-state recycling with wrap.
        drive(0, 0, 0, 1);
        step();
        drive(1, 0, 0, 0);
        repeat (10) step();
        for (int c = 0; c < 100; c++) begin
            drive(1, 1, out_q[0], 0);
            step();
        end
        check("steady_count", 32'(bus.free_count), 32'd54);

        // Overflow while full: sticky through flush, cleared by reset.
        async_reset_pulse();
        drive(0, 1, 5, 0);
        step();
        check("ovf_set", 32'(bus.overflow_err), 32'd1);
        drive(1, 1, 5, 0);
        step();
        drive(0, 0, 0, 1);
        step();
        check("ovf_after_flush", 32'(bus.overflow_err), 32'd1);
        async_reset_pulse();

        // Flush has priority over same-cycle alloc/free.
        drive(1, 0, 0, 0);
        repeat (20) step();
        drive(1, 1, out_q[0], 1);
        step();
        check("flush_count", 32'(bus.free_count), 32'd64);
        check("flush_tag", 32'(bus.alloc_tag), 32'd0);
        drive(1, 0, 0, 0);
        repeat (64) step();

        // Asynchronous reset mid-operation.
        drive(0, 0, 0, 1);
        step();
        drive(1, 0, 0, 0);
        repeat (30) step();
        async_reset_pulse();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bit a, f, fl;
            int ft;
            a  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 199) == 0);
            if (out_q.size() != 0) ft = out_q[$urandom_range(0, out_q.size() - 1)];
            else                   ft = int'($urandom_range(0, N_TAG - 1));
            drive(a, f, ft, fl);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
